// File: rtl/pool_window_gen_pkg.sv
// Shared packing definitions for the 2x2 window generator and the max-pooling stage.
package pool_window_gen_pkg;

  localparam int unsigned CH_DEF   = 4;
  localparam int unsigned W_BW_DEF = 8;

  localparam int unsigned WIN_TL = 0;
  localparam int unsigned WIN_TR = 1;
  localparam int unsigned WIN_BL = 2;
  localparam int unsigned WIN_BR = 3;
  localparam int unsigned WIN_N  = 4;

  // LSB of window element k of channel c inside the packed window bus.
  function automatic int unsigned win_lsb(input int unsigned c, input int unsigned k,
                                          input int unsigned w_bw);
    return (c * WIN_N + k) * w_bw;
  endfunction

endpackage

// File: rtl/pool_row_buf.sv
// Single-write / single-read line memory holding one even row of pixels.
module pool_row_buf
  import pool_window_gen_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [DEPTH];

  // Even-row pixel store; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/pool_window_gen.sv
// Streaming 2x2 / stride-2 window generator feeding the max-pooling stage.
// Optional macro POOL_WIN_SOF_SYNC_EN adds i_in_sof to realign counters to (row 0, col 0).
module pool_window_gen
  import pool_window_gen_pkg::*;
#(
  parameter int unsigned CH   = CH_DEF,
  parameter int unsigned W_BW = W_BW_DEF,
  parameter int unsigned IF_W = 8,
  parameter int unsigned IF_H = 8
)(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_in_pix_valid,
`ifdef POOL_WIN_SOF_SYNC_EN
  input  logic                      i_in_sof,
`endif
  input  logic [CH*W_BW-1:0]        i_in_pix,
  output logic                      o_ot_win_valid,
  output logic [CH*WIN_N*W_BW-1:0]  o_ot_win,
  output logic                      o_ot_frame_done
);

  localparam int unsigned PW = CH * W_BW;
  localparam int unsigned WW = CH * WIN_N * W_BW;
  localparam int unsigned AW = (IF_W > 1) ? $clog2(IF_W) : 1;
  localparam int unsigned RW = (IF_H > 1) ? $clog2(IF_H) : 1;

  localparam logic [AW-1:0] COL_LAST = AW'(IF_W - 1);
  localparam logic [AW-1:0] COL_ONE  = AW'(1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IF_H - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  logic [AW-1:0] col_q, col_d, col_cur;
  logic [RW-1:0] row_q, row_d, row_cur;
  logic [PW-1:0] prev_q, prev_d;
  logic [PW-1:0] tl_q, tl_d;
  logic [WW-1:0] win_q, win_d;
  logic          win_valid_q, win_valid_d;
  logic          frame_done_q, frame_done_d;
  logic [PW-1:0] rd_data;
  logic          wr_en;
  logic          sof;

`ifdef POOL_WIN_SOF_SYNC_EN
  assign sof = i_in_sof;
`else
  assign sof = 1'b0;
`endif

  pool_row_buf #(
    .DEPTH (IF_W),
    .DW    (PW),
    .AW    (AW)
  ) u_row_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (col_cur),
    .wr_data (i_in_pix),
    .rd_addr (col_cur),
    .rd_data (rd_data)
  );

  // Position tracking, row-buffer write and window assembly for the accepted pixel.
  always_comb begin
    col_cur      = sof ? {AW{1'b0}} : col_q;
    row_cur      = sof ? {RW{1'b0}} : row_q;
    col_d        = col_q;
    row_d        = row_q;
    prev_d       = prev_q;
    tl_d         = tl_q;
    win_d        = win_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    wr_en        = 1'b0;

    if (i_in_pix_valid) begin
      if (col_cur == COL_LAST) begin
        col_d = {AW{1'b0}};
        if (row_cur == ROW_LAST) begin
          row_d        = {RW{1'b0}};
          frame_done_d = 1'b1;
        end else begin
          row_d = row_cur + ROW_ONE;
        end
      end else begin
        col_d = col_cur + COL_ONE;
        row_d = row_cur;
      end

      if (!row_cur[0]) begin
        wr_en = 1'b1;
      end else begin
        prev_d = i_in_pix;
        // Even column latches the top-left so a single read port suffices.
        if (!col_cur[0]) begin
          tl_d = rd_data;
        end else begin
          win_valid_d = 1'b1;
          for (int unsigned c = 0; c < CH; c++) begin
            win_d[win_lsb(c, WIN_TL, W_BW) +: W_BW] = tl_q[c*W_BW +: W_BW];
            win_d[win_lsb(c, WIN_TR, W_BW) +: W_BW] = rd_data[c*W_BW +: W_BW];
            win_d[win_lsb(c, WIN_BL, W_BW) +: W_BW] = prev_q[c*W_BW +: W_BW];
            win_d[win_lsb(c, WIN_BR, W_BW) +: W_BW] = i_in_pix[c*W_BW +: W_BW];
          end
        end
      end
    end else begin
      wr_en = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q        <= {AW{1'b0}};
      row_q        <= {RW{1'b0}};
      prev_q       <= {PW{1'b0}};
      tl_q         <= {PW{1'b0}};
      win_q        <= {WW{1'b0}};
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      prev_q       <= prev_d;
      tl_q         <= tl_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_ot_win_valid  = win_valid_q;
  assign o_ot_win        = win_q;
  assign o_ot_frame_done = frame_done_q;

endmodule
